// File: rtl/mem_noc_arbiter_2to1_if.sv
// Request/response channel between a memory-NoC requester and its subordinate.
// The master drives requests and accepts responses; the slave does the reverse.
interface mem_noc_arbiter_2to1_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [AW-1:0]   req_addr;
  logic [DW-1:0]   req_data;
  logic            req_wen;
  logic [DW/8-1:0] req_wmask;
  logic            resp_valid;
  logic            resp_ready;
  logic [DW-1:0]   resp_data;

  modport master (
    output req_valid, req_addr, req_data, req_wen, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_wen, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_noc_arbiter_2to1.sv
// Round-robin 2:1 arbiter onto one memory-NoC port; a grant-ID FIFO steers
// in-order subordinate responses back to the requester that issued them.
module mem_noc_arbiter_2to1 #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int OST_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_noc_arbiter_2to1_if.slave        m0,
  mem_noc_arbiter_2to1_if.slave        m1,
  mem_noc_arbiter_2to1_if.master       s,
  output logic [$clog2(OST_DEPTH):0]   ost_cnt,
  output logic                         proto_err
);

  localparam int PW = $clog2(OST_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(OST_DEPTH);

  logic          r_rr_ptr;
  logic          r_lock;
  logic          r_lock_id;
  logic          r_proto_err;
  logic          r_fifo [OST_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_cnt;

  logic            w_full, w_empty;
  logic            w_gnt_vld, w_gnt_id, w_sel_vld;
  logic            w_s_req_vld, w_s_resp_rdy;
  logic            w_push, w_pop, w_stray, w_head;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_wmask;
  logic            w_wen;

  assign w_full  = (r_cnt == FULL_CNT);
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  // A pending (locked) request keeps its grant regardless of the other side.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = 1'b0;
    if (r_lock) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = r_lock_id;
    end else if (m0.req_valid && m1.req_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = r_rr_ptr;
    end else if (m0.req_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b0;
    end else if (m1.req_valid) begin
      w_gnt_vld = 1'b1;
      w_gnt_id  = 1'b1;
    end
  end

  assign w_sel_vld = w_gnt_id ? m1.req_valid : m0.req_valid;
  assign w_addr    = w_gnt_id ? m1.req_addr  : m0.req_addr;
  assign w_data    = w_gnt_id ? m1.req_data  : m0.req_data;
  assign w_wen     = w_gnt_id ? m1.req_wen   : m0.req_wen;
  assign w_wmask   = w_gnt_id ? m1.req_wmask : m0.req_wmask;

  assign w_s_req_vld = !rst && w_gnt_vld && w_sel_vld && !w_full;
  assign s.req_valid = w_s_req_vld;
  assign s.req_addr  = w_addr;
  assign s.req_data  = w_data;
  assign s.req_wen   = w_wen;
  assign s.req_wmask = w_wmask;

  assign m0.req_ready = !rst && w_gnt_vld && !w_gnt_id && s.req_ready && !w_full;
  assign m1.req_ready = !rst && w_gnt_vld &&  w_gnt_id && s.req_ready && !w_full;

  // With nothing outstanding, responses are swallowed and flagged as errors.
  assign w_s_resp_rdy  = !rst && (w_empty || (w_head ? m1.resp_ready : m0.resp_ready));
  assign s.resp_ready  = w_s_resp_rdy;
  assign m0.resp_valid = !rst && s.resp_valid && !w_empty && !w_head;
  assign m1.resp_valid = !rst && s.resp_valid && !w_empty &&  w_head;
  assign m0.resp_data  = s.resp_data;
  assign m1.resp_data  = s.resp_data;

  assign w_push  = w_s_req_vld && s.req_ready;
  assign w_pop   = s.resp_valid && w_s_resp_rdy && !w_empty;
  assign w_stray = s.resp_valid && w_s_resp_rdy &&  w_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_gnt_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= 1'b0;
      r_lock      <= 1'b0;
      r_lock_id   <= 1'b0;
      r_proto_err <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        r_rr_ptr <= ~w_gnt_id;
        r_lock   <= 1'b0;
      end else if (w_s_req_vld && !s.req_ready) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_gnt_id;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (PW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (PW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_stray) r_proto_err <= 1'b1;
    end
  end

  assign ost_cnt   = r_cnt;
  assign proto_err = r_proto_err;

endmodule
